// File: rtl/run_length_reporter.sv
// Run-length monitor: pulses hit on every REPS-th consecutive high sample and
// queues the (saturated) length of each completed run for a valid/ready consumer.
module run_length_reporter #(
  parameter int REPS  = 5,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a,
  output logic                     hit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LEN_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [LEN_W-1:0] MOD_LAST = LEN_W'(REPS - 1);
  localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(DEPTH);

  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] mod_cnt;
  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic pop;
  logic push_req;
  logic push_ok;

  assign out_valid = (level != '0);
  assign out_len   = out_valid ? mem[rd_ptr] : '0;

  // A full queue still takes a record when the head leaves on the same edge.
  assign pop      = out_valid & out_ready;
  assign push_req = ~a & (run_cnt != '0);
  assign push_ok  = push_req & ((level != FULL) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      mod_cnt  <= '0;
      hit      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (!a) begin
        run_cnt <= '0;
      end else if (run_cnt != LEN_MAX) begin
        run_cnt <= run_cnt + 1'b1;
      end

      // Multiple-of-REPS tracking keeps counting after run_cnt saturates.
      if (a && mod_cnt == MOD_LAST) begin
        mod_cnt <= '0;
        hit     <= 1'b1;
      end else if (a) begin
        mod_cnt <= mod_cnt + 1'b1;
        hit     <= 1'b0;
      end else begin
        mod_cnt <= '0;
        hit     <= 1'b0;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (push_ok && !pop) begin
        level <= level + 1'b1;
      end else if (!push_ok && pop) begin
        level <= level - 1'b1;
      end

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; entries are only visible through level/rd_ptr.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= run_cnt;
    end
  end

endmodule
